// File: rtl/controle_escrita_registradores.sv
`default_nettype none
// ============================================================================
// Module      : controle_escrita_registradores
// Description : Writeback sequencer for the register file. Latches a
//               writeback request (source + destination), drives the source
//               mux select, waits for multi-cycle sources (memory, input
//               device, HD), and issues one register-write pulse. Stalls the
//               control unit while busy and aborts HD accesses on timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module controle_escrita_registradores #(
    parameter int LAT_MEM     = 2,
    parameter int TIMEOUT_HD  = 255,
    parameter int LARGURA_REG = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inicia,
    input  logic [2:0]             fonte,
    input  logic [LARGURA_REG-1:0] reg_destino,
    input  logic                   input_pronto,
    input  logic                   hd_pronto,
    output logic [2:0]             controle,
    output logic                   escreve_reg,
    output logic [LARGURA_REG-1:0] reg_escrita,
    output logic                   input_req,
    output logic                   hd_req,
    output logic                   ocupado,
    output logic                   erro_timeout
);

    // Source codes (shared encoding for fonte and controle)
    localparam logic [2:0] C_FONTE_ULA   = 3'b000;
    localparam logic [2:0] C_FONTE_MEM   = 3'b001;
    localparam logic [2:0] C_FONTE_HD    = 3'b010;
    localparam logic [2:0] C_FONTE_INPUT = 3'b011;
    localparam logic [2:0] C_FONTE_PC    = 3'b100;

    // One counter serves both the memory latency and the HD timeout
    localparam int C_MAX_CNT = (LAT_MEM > TIMEOUT_HD) ? LAT_MEM : TIMEOUT_HD;
    localparam int C_CNT_W   = (C_MAX_CNT > 1) ? $clog2(C_MAX_CNT) : 1;
    localparam logic [C_CNT_W-1:0] C_MEM_INI = C_CNT_W'(LAT_MEM - 1);
    localparam logic [C_CNT_W-1:0] C_HD_LIM  = C_CNT_W'(TIMEOUT_HD - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_UM  = C_CNT_W'(1);

    typedef enum logic [2:0] {
        OCIOSO       = 3'd0,
        ESPERA_MEM   = 3'd1,
        ESPERA_INPUT = 3'd2,
        ESPERA_HD    = 3'd3,
        ESCREVE      = 3'd4
    } estado_t;

    estado_t                r_estado;
    logic [C_CNT_W-1:0]     r_cnt;
    logic [2:0]             r_controle;
    logic [LARGURA_REG-1:0] r_reg_escrita;
    logic                   r_escreve;
    logic                   r_input_req;
    logic                   r_hd_req;
    logic                   r_ocupado;
    logic                   r_erro;
    // ESCREVE spans two cycles: the pulse cycle, then the return to idle.
    // This flag marks that the pulse has already been issued.
    logic                   r_pulsado;
    logic [2:0]             w_fonte_norm;

    // Normalise unknown source codes to PC
    always_comb begin
        w_fonte_norm = C_FONTE_PC;
        case (fonte)
            C_FONTE_ULA, C_FONTE_MEM, C_FONTE_HD, C_FONTE_INPUT:
                w_fonte_norm = fonte;
            default:
                w_fonte_norm = C_FONTE_PC;
        endcase
    end

    // Writeback sequencing FSM with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado      <= OCIOSO;
            r_cnt         <= '0;
            r_controle    <= C_FONTE_ULA;
            r_reg_escrita <= '0;
            r_escreve     <= 1'b0;
            r_input_req   <= 1'b0;
            r_hd_req      <= 1'b0;
            r_ocupado     <= 1'b0;
            r_erro        <= 1'b0;
            r_pulsado     <= 1'b0;
        end else begin
            r_escreve <= 1'b0;
            r_erro    <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (inicia) begin
                        r_controle    <= w_fonte_norm;
                        r_reg_escrita <= reg_destino;
                        r_ocupado     <= 1'b1;
                        r_pulsado     <= 1'b0;
                        case (w_fonte_norm)
                            C_FONTE_MEM: begin
                                r_estado <= ESPERA_MEM;
                                r_cnt    <= C_MEM_INI;
                            end
                            C_FONTE_INPUT: begin
                                r_estado    <= ESPERA_INPUT;
                                r_input_req <= 1'b1;
                            end
                            C_FONTE_HD: begin
                                r_estado <= ESPERA_HD;
                                r_hd_req <= 1'b1;
                                r_cnt    <= '0;
                            end
                            default: begin
                                r_estado <= ESCREVE;
                            end
                        endcase
                    end
                end
                ESPERA_MEM: begin
                    if (r_cnt == '0) begin
                        r_estado <= ESCREVE;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_UM;
                    end
                end
                ESPERA_INPUT: begin
                    if (input_pronto) begin
                        r_input_req <= 1'b0;
                        r_estado    <= ESCREVE;
                    end
                end
                ESPERA_HD: begin
                    // Data arriving on the limit cycle still counts as success
                    if (hd_pronto) begin
                        r_hd_req <= 1'b0;
                        r_estado <= ESCREVE;
                    end else if (r_cnt == C_HD_LIM) begin
                        r_hd_req  <= 1'b0;
                        r_erro    <= 1'b1;
                        r_ocupado <= 1'b0;
                        r_estado  <= OCIOSO;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_UM;
                    end
                end
                ESCREVE: begin
                    if (!r_pulsado) begin
                        // r0 is hard-wired; suppress the write but keep timing
                        r_escreve <= (r_reg_escrita != '0);
                        r_pulsado <= 1'b1;
                    end else begin
                        r_ocupado <= 1'b0;
                        r_estado  <= OCIOSO;
                    end
                end
                default: begin
                    r_ocupado   <= 1'b0;
                    r_input_req <= 1'b0;
                    r_hd_req    <= 1'b0;
                    r_estado    <= OCIOSO;
                end
            endcase
        end
    end

    assign controle     = r_controle;
    assign escreve_reg  = r_escreve;
    assign reg_escrita  = r_reg_escrita;
    assign input_req    = r_input_req;
    assign hd_req       = r_hd_req;
    assign ocupado      = r_ocupado;
    assign erro_timeout = r_erro;

endmodule
`default_nettype wire
